// File: rtl/intr_ctrl_if.sv
// intr_ctrl_if: CPU interrupt handshake plus register port of the interrupt controller
interface intr_ctrl_if;
  logic        intr;
  logic        inta;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  modport master (input intr, rdata, output inta, sel, we, addr, wdata);
  modport slave (output intr, rdata, input inta, sel, we, addr, wdata);
endinterface

// File: rtl/intr_ctrl.sv
// intr_ctrl: edge-capturing prioritised interrupt controller with mask, vector and EOI registers
module intr_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic [N-1:0] src,
  intr_ctrl_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;
  state_t state;
  logic [N-1:0] src_q, pend, mask, rise, cand, live, pend_clr, ack_clr;
  logic         vec_v, wr_pend, wr_mask, wr_eoi, ack;
  logic [3:0]   vec_id, id;
  assign rise     = src & ~src_q;
  assign wr_pend  = bus.sel & bus.we & (bus.addr == 2'd0);
  assign wr_mask  = bus.sel & bus.we & (bus.addr == 2'd1);
  assign wr_eoi   = bus.sel & bus.we & (bus.addr == 2'd3);
  assign pend_clr = wr_pend ? bus.wdata[N-1:0] : '0;
  assign cand     = pend & mask;
  // a software clear in the same cycle as an acknowledge wins, so the CPU sees a spurious vector
  assign live     = cand & ~pend_clr;
  assign ack      = (state == REQ) & bus.inta & (|live);
  assign bus.rdata = !bus.sel ? 32'd0 :
                     bus.addr == 2'd0 ? 32'(pend) :
                     bus.addr == 2'd1 ? 32'(mask) :
                     bus.addr == 2'd2 ? {vec_v, 27'd0, vec_id} : 32'd0;
  // lowest set index of the live candidates wins; its pending bit is cleared on acknowledge
  always_comb begin
    id = '0;
    ack_clr = '0;
    for (int i = N - 1; i >= 0; i--)
      if (live[i]) begin
        id = 4'(i);
        ack_clr = '0;
        ack_clr[i] = ack;
      end
  end
  // edge capture, write-1-to-clear pending (new edges win) and mask register
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      src_q <= '0;
      pend  <= '0;
      mask  <= '0;
    end else begin
      src_q <= src;
      pend  <= (pend & ~pend_clr & ~ack_clr) | rise;
      if (wr_mask) mask <= bus.wdata[N-1:0];
    end
  // request/service state machine with registered intr and vector
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      state   <= IDLE;
      bus.intr <= 1'b0;
      vec_v   <= 1'b0;
      vec_id  <= '0;
    end else
      case (state)
        IDLE:
          if (|cand) begin
            state   <= REQ;
            bus.intr <= 1'b1;
          end
        REQ:
          if (bus.inta || !(|live)) begin
            state   <= ack ? SVC : IDLE;
            bus.intr <= 1'b0;
            if (bus.inta) begin
              vec_v  <= ack;
              vec_id <= ack ? id : 4'd0;
            end
          end
        SVC:
          if (wr_eoi) begin
            state  <= IDLE;
            vec_v  <= 1'b0;
            vec_id <= '0;
          end
        default: state <= IDLE;
      endcase
endmodule
